hs_bus_master: RTL and testbench

Initiator side of the 4-way handshake data bus used by the SoC's memory-mapped peripherals (LED, switches, UART, etc.). It accepts single-cycle read/write requests from the processor-side port, drives the registered Read/Write strobe, address and write data to a peripheral until Ack rises, then releases the strobe and waits for Ack to fall before reporting completion. A per-phase timeout guarantees forward progress when a peripheral is absent or hung, and reports the failure as an error response.

---
 rtl/hs_pkg.sv | 19 +
 rtl/hs_timeout.sv | 37 +++
 rtl/hs_bus_master.sv | 142 ++++++++++++++
 tb/tb_hs_bus_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and constants for the 4-phase handshake bus master.
// Holds the FSM state encoding, the default phase timeout and timer sizing.
package hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } hs_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd255;
    localparam int unsigned MAX_TIMEOUT     = 32'd65535;

    // Bits needed for a counter that must be able to hold the value `timeout`.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 32'd1);
    endfunction

endpackage

// File: rtl/hs_timeout.sv
// Clearable saturating phase timer; expired rises on the cycle whose
// closing edge is the TIMEOUT-th enabled edge since the last clear.
module hs_timeout
    import hs_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = timer_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] count_r;

    // Phase counter: clear wins over enable, holds once saturated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_SAT)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r >= CNT_TERM);

endmodule

// File: rtl/hs_bus_master.sv
// Initiator for the 4-phase Read/Write/Ack peripheral bus: registered strobes,
// per-phase timeout, one-cycle completion pulse with error status.
module hs_bus_master
    import hs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32'd30,
    parameter int unsigned DATA_WIDTH = 32'd32,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_write,
    output logic                  bus_read,
    input  logic                  bus_ack
);

    hs_state_t             state_r;
    logic                  write_r;
    logic                  error_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  expired_s;
    logic                  timer_clear_s;
    logic                  timer_en_s;

    hs_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // A new request is only taken once the previous peripheral has dropped Ack.
    assign req_ready = (state_r == ST_IDLE) && !bus_ack;

    // Timer control: restart on every phase change, idle keeps it at zero.
    always_comb begin
        timer_clear_s = 1'b1;
        timer_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_clear_s = 1'b1;
                timer_en_s    = 1'b0;
            end
            ST_REQ: begin
                timer_clear_s = bus_ack || expired_s;
                timer_en_s    = 1'b1;
            end
            ST_REL: begin
                timer_clear_s = !bus_ack || expired_s;
                timer_en_s    = 1'b1;
            end
            default: begin
                timer_clear_s = 1'b1;
                timer_en_s    = 1'b0;
            end
        endcase
    end

    // Handshake FSM with all bus and response outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            write_r   <= 1'b0;
            error_r   <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= {ADDR_WIDTH{1'b0}};
            bus_wdata <= {DATA_WIDTH{1'b0}};
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        write_r   <= req_write;
                        error_r   <= 1'b0;
                        rdata_r   <= {DATA_WIDTH{1'b0}};
                        bus_addr  <= req_addr;
                        bus_wdata <= req_wdata;
                        bus_read  <= !req_write;
                        bus_write <= req_write;
                        state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        if (!write_r) begin
                            rdata_r <= bus_rdata;
                        end
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state_r   <= ST_REL;
                    end else if (expired_s) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        error_r   <= 1'b1;
                        state_r   <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!bus_ack) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= error_r;
                        rsp_rdata <= (error_r || write_r) ? {DATA_WIDTH{1'b0}} : rdata_r;
                        state_r   <= ST_IDLE;
                    end else if (expired_s) begin
                        // Peripheral never released Ack; req_ready stays low until it does.
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    bus_read  <= 1'b0;
                    bus_write <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_bus_master.sv
// Bench for hs_bus_master: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hs_bus_master;

    localparam int T = 8;
    localparam int MODE_REG   = 0;
    localparam int MODE_NONE  = 1;
    localparam int MODE_STUCK = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [29:0] req_addr  = 30'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_rdata;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0000_01A5;
    logic        bus_write;
    logic        bus_read;
    logic        bus_ack = 1'b0;

    int mode = MODE_REG;
    logic stuck_hold = 1'b0;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    hs_bus_master #(
        .ADDR_WIDTH (30),
        .DATA_WIDTH (32),
        .TIMEOUT    (T)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_error (rsp_error),
        .rsp_rdata (rsp_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_ack   (bus_ack)
    );

    always #5 clock = ~clock;

    // Cycle counter and peripheral responder (registered Ack, absent, or stuck high).
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            bus_ack <= 1'b0;
        end else begin
            case (mode)
                MODE_REG:  bus_ack <= bus_read | bus_write;
                MODE_NONE: bus_ack <= 1'b0;
                default:   bus_ack <= stuck_hold & (bus_ack | bus_read | bus_write);
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: one outstanding transaction described by its timeline in cycle numbers.
    logic        m_active = 1'b0;
    int          m_a, m_slast, m_rsp;
    logic        m_write, m_err;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    initial begin
        logic e_str, e_rd, e_wr, e_rsp, e_err, e_ready;
        logic [31:0] e_rdata;
        int n;
        forever begin
            @(negedge clock);
            n = cyc;
            if (!reset) begin
                m_active = 1'b0;
                e_str = 1'b0;
                e_rsp = 1'b0;
            end else begin
                e_str = m_active && (n >= m_a) && (n <= m_slast);
                e_rsp = m_active && (n == m_rsp);
            end
            e_rd    = e_str && !m_write;
            e_wr    = e_str && m_write;
            e_err   = e_rsp ? m_err : 1'b0;
            e_rdata = e_rsp ? m_rdata : 32'd0;
            e_ready = (!m_active || (n >= m_rsp)) && !bus_ack;
            chk("bus_read", 64'(bus_read), 64'(e_rd));
            chk("bus_write", 64'(bus_write), 64'(e_wr));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("rsp_error", 64'(rsp_error), 64'(e_err));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            if (e_str) begin
                chk("bus_addr", 64'(bus_addr), 64'(m_addr));
                chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
            end
            if (reset && e_ready && req_valid) begin
                m_active = 1'b1;
                m_a      = n + 1;
                m_write  = req_write;
                m_addr   = req_addr;
                m_wdata  = req_wdata;
                case (mode)
                    MODE_REG: begin
                        m_slast = m_a + 1;
                        m_rsp   = m_a + 4;
                        m_err   = 1'b0;
                        m_rdata = req_write ? 32'd0 : bus_rdata;
                    end
                    MODE_NONE: begin
                        m_slast = m_a + T - 1;
                        m_rsp   = m_a + T + 1;
                        m_err   = 1'b1;
                        m_rdata = 32'd0;
                    end
                    default: begin
                        m_slast = m_a + 1;
                        m_rsp   = m_a + T + 2;
                        m_err   = 1'b1;
                        m_rdata = 32'd0;
                    end
                endcase
            end
        end
    end

    // Results of the last do_req call.
    int          t_strobe, t_lat;
    logic        t_rsp, t_err, t_rd_seen, t_wr_seen;
    logic [31:0] t_rdata, t_wdata;
    logic [29:0] t_addr;

    task automatic wait_accept();
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: req_ready never rose (cycle %0d)", cyc);
        end
    endtask

    task automatic do_req(input logic w, input logic [29:0] ad, input logic [31:0] wd);
        @(posedge clock); #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = ad;
        req_wdata = wd;
        wait_accept();
        @(posedge clock); #1;
        req_valid = 1'b0;
        t_strobe = 0; t_lat = -1; t_rsp = 1'b0; t_err = 1'b0; t_rdata = 32'd0;
        t_rd_seen = 1'b0; t_wr_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i == 0) begin
                t_addr  = bus_addr;
                t_wdata = bus_wdata;
            end
            if (bus_read)  t_rd_seen = 1'b1;
            if (bus_write) t_wr_seen = 1'b1;
            if (bus_read | bus_write) t_strobe++;
            if (rsp_valid) begin
                t_rsp = 1'b1; t_lat = i; t_err = rsp_error; t_rdata = rsp_rdata;
                break;
            end
        end
        chk("rsp_seen", 64'(t_rsp), 64'd1);
    endtask

    initial begin
        int r1, w1;
        repeat (3) @(negedge clock);
        chk("rst_bus_read", 64'(bus_read), 64'd0);
        chk("rst_bus_write", 64'(bus_write), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #2 reset = 1'b1;

        // Read with registered-Ack responder
        do_req(1'b0, 30'h4, 32'h0);
        chk("rd_strobe_cycles", 64'(t_strobe), 64'd2);
        chk("rd_latency", 64'(t_lat), 64'd4);
        chk("rd_rdata", 64'(t_rdata), 64'h1A5);
        chk("rd_error", 64'(t_err), 64'd0);
        chk("rd_no_write", 64'(t_wr_seen), 64'd0);

        // Write 0xFF to 0x10
        do_req(1'b1, 30'h10, 32'h0FF);
        chk("wr_addr", 64'(t_addr), 64'h10);
        chk("wr_wdata", 64'(t_wdata), 64'hFF);
        chk("wr_rdata", 64'(t_rdata), 64'd0);
        chk("wr_error", 64'(t_err), 64'd0);
        chk("wr_no_read", 64'(t_rd_seen), 64'd0);
        chk("wr_strobe_cycles", 64'(t_strobe), 64'd2);

        // Back-to-back read then write with req_valid held
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'h20; req_wdata = 32'd0;
        wait_accept();
        @(posedge clock); #1;
        req_write = 1'b1; req_addr = 30'h24; req_wdata = 32'h55;
        r1 = -100;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                r1 = cyc;
                break;
            end
        end
        chk("b2b_first_rdata", 64'(rsp_rdata), 64'h1A5);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        w1 = bus_write ? cyc : -1;
        chk("b2b_gap", 64'(w1 - r1), 64'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        chk("b2b_second_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_second_err", 64'(rsp_error), 64'd0);

        // Absent peripheral: REQ-phase timeout
        @(posedge clock); #1 mode = MODE_NONE;
        do_req(1'b0, 30'h3F, 32'd0);
        chk("noack_strobe_cycles", 64'(t_strobe), 64'd8);
        chk("noack_latency", 64'(t_lat), 64'd9);
        chk("noack_error", 64'(t_err), 64'd1);
        chk("noack_rdata", 64'(t_rdata), 64'd0);

        // Ack stuck high: REL-phase timeout, then ready gated by Ack
        @(posedge clock); #1 mode = MODE_STUCK; stuck_hold = 1'b1;
        do_req(1'b1, 30'h11, 32'hA5A5);
        chk("stuck_strobe_cycles", 64'(t_strobe), 64'd2);
        chk("stuck_latency", 64'(t_lat), 64'd10);
        chk("stuck_error", 64'(t_err), 64'd1);
        chk("stuck_rdata", 64'(t_rdata), 64'd0);
        repeat (3) begin
            @(negedge clock);
            chk("stuck_ready_low", 64'(req_ready), 64'd0);
        end
        @(posedge clock); #1 stuck_hold = 1'b0;
        @(negedge clock);
        chk("stuck_ready_still_low", 64'(req_ready), 64'd0);
        @(negedge clock);
        chk("stuck_ready_released", 64'(req_ready), 64'd1);
        @(posedge clock); #1 mode = MODE_REG;

        // Reset during REQ
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'h30;
        wait_accept();
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rst_pre_strobe", 64'(bus_read), 64'd1);
        #1 reset = 1'b0;
        #1 chk("rst_async_strobe", 64'(bus_read), 64'd0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clock); #2 reset = 1'b1;
        bus_rdata = 32'h0000_BEEF;
        do_req(1'b0, 30'h31, 32'd0);
        chk("post_rst_rdata", 64'(t_rdata), 64'hBEEF);
        chk("post_rst_latency", 64'(t_lat), 64'd4);
        chk("post_rst_error", 64'(t_err), 64'd0);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
